// File: rtl/fir_sequencer.sv
// fir_sequencer: upstream control stage for a 16-tap FIR core.
//
// Accepts a full coefficient set, then one sample at a time, on valid/ready streams. It drives
// the core's wind/load/in_valid/data pins and captures the core result into a one-entry buffer
// presented on a valid/ready output stream. A watchdog aborts a sample if the core never answers.
//
// Ports
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   cfg_clear                  pulse: drop coefficients and any pending work, back to unconfigured
//   coef_valid/ready/data      coefficient input stream (ready only while unconfigured)
//   smp_valid/ready/data       sample input stream (ready only while idle and configured)
//   res_valid/ready/data       result output stream (one-entry buffer)
//   coef_loaded                full coefficient set present
//   err_timeout                sticky: core did not raise out_valid in time
//   fir_rst/wind/load/in_valid/data   registered drive to the core
//   fir_out_valid, fir_out     core result
module fir_sequencer #(
    parameter int unsigned TAPS       = 16,
    parameter int unsigned VLD_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_clear,
    input  logic        coef_valid,
    output logic        coef_ready,
    input  logic [15:0] coef_data,
    input  logic        smp_valid,
    output logic        smp_ready,
    input  logic [15:0] smp_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        coef_loaded,
    output logic        err_timeout,
    output logic        fir_rst,
    output logic        fir_wind,
    output logic        fir_load,
    output logic        fir_in_valid,
    output logic [15:0] fir_data,
    input  logic        fir_out_valid,
    input  logic [15:0] fir_out
);

    localparam int unsigned CntW = $clog2(TAPS) + 1;
    localparam int unsigned TmrW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        StUncfg,
        StIdle,
        StLoad,
        StFire,
        StWait,
        StHold
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   coef_cnt_q, coef_cnt_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic              fir_rst_q, fir_rst_d;
    logic              fir_wind_q, fir_wind_d;
    logic              fir_load_q, fir_load_d;
    logic              fir_in_valid_q, fir_in_valid_d;
    logic [15:0]       fir_data_q, fir_data_d;
    logic              res_valid_q, res_valid_d;
    logic [15:0]       res_data_q, res_data_d;
    logic              coef_loaded_q, coef_loaded_d;
    logic              err_timeout_q, err_timeout_d;

    assign coef_ready = (state_q == StUncfg);
    assign smp_ready  = (state_q == StIdle);

    always_comb begin
        state_d       = state_q;
        coef_cnt_d    = coef_cnt_q;
        timer_d       = timer_q;
        fir_rst_d     = 1'b0;
        fir_wind_d    = 1'b0;
        fir_load_d    = 1'b0;
        fir_data_d    = fir_data_q;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        coef_loaded_d = coef_loaded_q;
        err_timeout_d = err_timeout_q;

        if (cfg_clear) begin
            // Any handshake in this cycle is discarded; the core is reset for one cycle.
            state_d       = StUncfg;
            coef_cnt_d    = '0;
            coef_loaded_d = 1'b0;
            res_valid_d   = 1'b0;
            fir_rst_d     = 1'b1;
        end else begin
            unique case (state_q)
                StUncfg: begin
                    if (coef_valid) begin
                        fir_wind_d = 1'b1;
                        fir_data_d = coef_data;
                        coef_cnt_d = coef_cnt_q + 1'b1;
                        if (coef_cnt_q == CntW'(TAPS - 1)) begin
                            state_d       = StIdle;
                            coef_loaded_d = 1'b1;
                        end
                    end
                end
                StIdle: begin
                    if (smp_valid) begin
                        fir_load_d = 1'b1;
                        fir_data_d = smp_data;
                        state_d    = StLoad;
                    end
                end
                StLoad: begin
                    state_d = StFire;
                    timer_d = '0;
                end
                StFire, StWait: begin
                    // A result arriving on the last allowed cycle still wins over the abort.
                    if (fir_out_valid) begin
                        res_data_d  = fir_out;
                        res_valid_d = 1'b1;
                        state_d     = StHold;
                    end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
                        err_timeout_d = 1'b1;
                        state_d       = StIdle;
                    end else begin
                        timer_d = timer_q + 1'b1;
                        if (state_q == StFire && timer_q == TmrW'(VLD_CYCLES - 1)) begin
                            state_d = StWait;
                        end
                    end
                end
                StHold: begin
                    if (res_ready) begin
                        res_valid_d = 1'b0;
                        state_d     = StIdle;
                    end
                end
                default: state_d = StUncfg;
            endcase
        end

        // in_valid is high exactly while the next state is the firing phase.
        fir_in_valid_d = (state_d == StFire);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StUncfg;
            coef_cnt_q     <= '0;
            timer_q        <= '0;
            fir_rst_q      <= 1'b1;
            fir_wind_q     <= 1'b0;
            fir_load_q     <= 1'b0;
            fir_in_valid_q <= 1'b0;
            fir_data_q     <= '0;
            res_valid_q    <= 1'b0;
            res_data_q     <= '0;
            coef_loaded_q  <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            coef_cnt_q     <= coef_cnt_d;
            timer_q        <= timer_d;
            fir_rst_q      <= fir_rst_d;
            fir_wind_q     <= fir_wind_d;
            fir_load_q     <= fir_load_d;
            fir_in_valid_q <= fir_in_valid_d;
            fir_data_q     <= fir_data_d;
            res_valid_q    <= res_valid_d;
            res_data_q     <= res_data_d;
            coef_loaded_q  <= coef_loaded_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    assign fir_rst      = fir_rst_q;
    assign fir_wind     = fir_wind_q;
    assign fir_load     = fir_load_q;
    assign fir_in_valid = fir_in_valid_q;
    assign fir_data     = fir_data_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign coef_loaded  = coef_loaded_q;
    assign err_timeout  = err_timeout_q;

endmodule
